// File: rtl/timer_counter_pkg.sv
// Shared definitions for the memory-mapped down-counting timer.
package timer_counter_pkg;

  // Word offsets decoded from addr[3:2]
  localparam logic [1:0] TC_CTRL   = 2'b00;
  localparam logic [1:0] TC_PRESET = 2'b01;
  localparam logic [1:0] TC_COUNT  = 2'b10;

  // CTRL field positions
  localparam int unsigned CTRL_EN      = 0;
  localparam int unsigned CTRL_MODE_LO = 1;
  localparam int unsigned CTRL_MODE_HI = 2;
  localparam int unsigned CTRL_IM      = 3;

  // Only mode 01 reloads; 00, 10 and 11 are one-shot
  localparam logic [1:0] MODE_PERIODIC = 2'b01;

  typedef enum logic [1:0] {
    TC_IDLE = 2'b00,
    TC_LOAD = 2'b01,
    TC_CNT  = 2'b10,
    TC_INT  = 2'b11
  } tc_state_e;

endpackage

// File: rtl/timer_counter.sv
// Down-counting timer with CTRL/PRESET/COUNT registers and a masked interrupt.
module timer_counter
  import timer_counter_pkg::*;
#(
  parameter logic [31:0] PRESET_INIT = 32'h0000_0000,
  parameter logic [31:0] CTRL_MASK   = 32'h0000_000F
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  tc_state_e   state_q, state_d;
  logic [31:0] ctrl_q, ctrl_d;
  logic [31:0] preset_q;
  logic [31:0] count_q, count_d;
  logic        flag_q, flag_d;
  logic        irq_q, irq_d;
  logic        ctrl_wr, preset_wr;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^{addr[31:4], addr[1:0]};
  assign ctrl_wr   = we && (addr[3:2] == TC_CTRL);
  assign preset_wr = we && (addr[3:2] == TC_PRESET);
  assign irq       = irq_q;

  // Next-state, counter and flag update; a CTRL write overrides the FSM's own CTRL/flag changes
  always_comb begin
    state_d = state_q;
    ctrl_d  = ctrl_q;
    count_d = count_q;
    flag_d  = flag_q;
    unique case (state_q)
      TC_IDLE: begin
        if (ctrl_q[CTRL_EN]) state_d = TC_LOAD;
      end
      TC_LOAD: begin
        count_d = preset_q;
        state_d = TC_CNT;
      end
      TC_CNT: begin
        if (!ctrl_q[CTRL_EN]) begin
          state_d = TC_IDLE;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          count_d = '0;
          flag_d  = 1'b1;
          state_d = TC_INT;
        end
      end
      TC_INT: begin
        state_d = TC_IDLE;
        if (ctrl_q[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_PERIODIC) flag_d = 1'b0;
        else ctrl_d[CTRL_EN] = 1'b0;
      end
      default: state_d = TC_IDLE;
    endcase
    if (ctrl_wr) begin
      ctrl_d = wdata & CTRL_MASK;
      flag_d = 1'b0;
    end
    // irq is held one cycle past a periodic flag clear so the pulse spans INT and the
    // following IDLE; computing it here keeps the output a single flop
    irq_d = ctrl_d[CTRL_IM] & (flag_d | (flag_q & ~ctrl_wr));
  end

  // State and register storage
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= TC_IDLE;
      ctrl_q   <= '0;
      preset_q <= PRESET_INIT;
      count_q  <= '0;
      flag_q   <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      count_q <= count_d;
      flag_q  <= flag_d;
      irq_q   <= irq_d;
      if (preset_wr) preset_q <= wdata;
    end
  end

  // Combinational, side-effect-free register read
  always_comb begin
    rdata = '0;
    case (addr[3:2])
      TC_CTRL:   rdata = ctrl_q;
      TC_PRESET: rdata = preset_q;
      TC_COUNT:  rdata = count_q;
      default:   rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_timer_counter.sv
// Self-checking bench for timer_counter: directed scenarios plus randomized runs against a timeline model.
module tb_timer_counter;

  localparam logic [31:0] P_INIT = 32'h0000_00A5;
  localparam logic [31:0] A_CTRL   = 32'h0000_7F00;
  localparam logic [31:0] A_PRESET = 32'h0000_7F04;
  localparam logic [31:0] A_COUNT  = 32'h0000_7F08;
  localparam logic [31:0] A_RSVD   = 32'h0000_7F0C;

  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  int errors = 0;
  int checks = 0;

  timer_counter #(.PRESET_INIT(P_INIT), .CTRL_MASK(32'h0000_000F)) dut (
    .clk(clk), .reset(reset), .addr(addr), .we(we),
    .wdata(wdata), .rdata(rdata), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Timeline model. m = edges since CNT entry (m=0: first CNT cycle showing COUNT=P).
  // A run lasts max(P,1) CNT cycles; periodic mode repeats every run+3 cycles (INT, IDLE, LOAD).
  function automatic int unsigned run_len(input int unsigned p);
    return (p == 0) ? 1 : p;
  endfunction

  function automatic logic [31:0] exp_count(input int unsigned p, input int unsigned mode, input int unsigned m);
    int unsigned pe = run_len(p);
    int unsigned r;
    r = (mode == 1) ? (m % (pe + 3)) : ((m > pe) ? pe + 1 : m);
    if (r <= pe && p > r) return p - r;
    return 32'd0;
  endfunction

  function automatic logic exp_irq(input int unsigned p, input int unsigned mode, input logic im, input int unsigned m);
    int unsigned pe = run_len(p);
    int unsigned r;
    if (!im) return 1'b0;
    if (mode == 1) begin
      r = m % (pe + 3);
      return (r == pe) || (r == pe + 1);
    end
    return m >= pe;
  endfunction

  // Called at a negedge; the write lands on the following posedge, returns at the next negedge
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; we = 1'b1;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic do_reset();
    we = 1'b0; addr = A_CTRL; wdata = '0;
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] exp [4];
    logic [31:0] offs [4];
    exp[0] = 32'h0; exp[1] = P_INIT; exp[2] = 32'h0; exp[3] = 32'h0;
    offs[0] = A_CTRL; offs[1] = A_PRESET; offs[2] = A_COUNT; offs[3] = A_RSVD;
    do_reset();
    wr(A_PRESET, 32'h1234);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      addr = offs[i];
      #1;
      checks++;
      if (rdata !== exp[i]) begin
        errors++;
        $display("FAIL reset_read[%0d]: got %h expected %h", i, rdata, exp[i]);
      end
    end
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_irq: got %b expected 0", irq);
    end
  endtask

  task automatic test_oneshot();
    do_reset();
    wr(A_PRESET, 32'd5);
    wr(A_CTRL, 32'h9);
    addr = A_COUNT;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        checks++;
        if (rdata !== exp_count(5, 0, k - 2) || irq !== exp_irq(5, 0, 1'b1, k - 2)) begin
          errors++;
          $display("FAIL oneshot_m%0d: count=%0d irq=%b expected count=%0d irq=%b",
                   k - 2, rdata, irq, exp_count(5, 0, k - 2), exp_irq(5, 0, 1'b1, k - 2));
        end
      end
    end
    addr = A_CTRL; #1;
    checks++;
    if (rdata !== 32'h8) begin
      errors++;
      $display("FAIL oneshot_ctrl: got %h expected 00000008", rdata);
    end
    wr(A_CTRL, 32'h0);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL oneshot_ack: irq got %b expected 0", irq);
    end
  endtask

  task automatic test_periodic();
    do_reset();
    wr(A_PRESET, 32'd3);
    wr(A_CTRL, 32'hB);
    addr = A_COUNT;
    for (int k = 1; k <= 21; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        checks++;
        if (rdata !== exp_count(3, 1, k - 2) || irq !== exp_irq(3, 1, 1'b1, k - 2)) begin
          errors++;
          $display("FAIL periodic_m%0d: count=%0d irq=%b expected count=%0d irq=%b",
                   k - 2, rdata, irq, exp_count(3, 1, k - 2), exp_irq(3, 1, 1'b1, k - 2));
        end
      end
    end
    addr = A_CTRL; #1;
    checks++;
    if (rdata !== 32'hB) begin
      errors++;
      $display("FAIL periodic_ctrl: got %h expected 0000000b", rdata);
    end
  endtask

  task automatic test_freeze();
    bit found = 0;
    do_reset();
    wr(A_PRESET, 32'd10);
    wr(A_CTRL, 32'h9);
    for (int k = 0; k < 3; k++) @(negedge clk);
    wr(A_PRESET, 32'd7);
    addr = A_COUNT;
    for (int i = 0; i < 30 && !found; i++) begin
      #1;
      if (rdata == 32'd4) found = 1;
      else @(negedge clk);
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL freeze_wait: count never reached 4, last %0d", rdata);
    end
    wr(A_CTRL, 32'h8);
    addr = A_COUNT;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if (rdata !== 32'd3 || irq !== 1'b0) begin
        errors++;
        $display("FAIL freeze_hold[%0d]: count=%0d irq=%b expected count=3 irq=0", k, rdata, irq);
      end
      @(negedge clk);
    end
    wr(A_CTRL, 32'h9);
    addr = A_COUNT;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (rdata !== 32'd7) begin
      errors++;
      $display("FAIL freeze_reload: got %0d expected 7", rdata);
    end
  endtask

  task automatic test_p0_p1();
    for (int p = 0; p < 2; p++) begin
      do_reset();
      wr(A_PRESET, p);
      wr(A_CTRL, 32'h9);
      addr = A_COUNT;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (rdata !== p || irq !== 1'b0) begin
        errors++;
        $display("FAIL p%0d_entry: count=%0d irq=%b expected count=%0d irq=0", p, rdata, irq, p);
      end
      @(negedge clk);
      checks++;
      if (rdata !== 32'd0 || irq !== 1'b1) begin
        errors++;
        $display("FAIL p%0d_fire: count=%0d irq=%b expected count=0 irq=1", p, rdata, irq);
      end
      wr(A_COUNT, 32'hFFFF);
      #1;
      checks++;
      if (rdata !== 32'd0) begin
        errors++;
        $display("FAIL p%0d_count_ro: got %h expected 00000000", p, rdata);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    wr(A_PRESET, 32'd2);
    wr(A_CTRL, 32'h9);
    for (int k = 0; k < 5; k++) @(negedge clk);
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL areset_pre_irq: got %b expected 1", irq);
    end
    reset = 1'b0; addr = A_CTRL;
    #1;
    checks++;
    if (irq !== 1'b0 || rdata !== 32'h0) begin
      errors++;
      $display("FAIL areset_irq_ctrl: irq=%b ctrl=%h expected irq=0 ctrl=0", irq, rdata);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    wr(A_PRESET, 32'd20);
    wr(A_CTRL, 32'h9);
    addr = A_COUNT;
    for (int k = 0; k < 6; k++) @(negedge clk);
    checks++;
    if (rdata !== 32'd16) begin
      errors++;
      $display("FAIL areset_pre_count: got %0d expected 16", rdata);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (rdata !== 32'd0) begin
      errors++;
      $display("FAIL areset_count: got %0d expected 0", rdata);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_int_collision();
    do_reset();
    wr(A_PRESET, 32'd2);
    wr(A_CTRL, 32'h9);
    for (int k = 0; k < 4; k++) @(negedge clk);
    wr(A_CTRL, 32'h9);
    addr = A_CTRL; #1;
    checks++;
    if (rdata !== 32'h9 || irq !== 1'b0) begin
      errors++;
      $display("FAIL collision_ctrl: ctrl=%h irq=%b expected ctrl=00000009 irq=0", rdata, irq);
    end
    addr = A_COUNT;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (rdata !== 32'd2) begin
      errors++;
      $display("FAIL collision_reload: got %0d expected 2", rdata);
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 8; t++) begin
      int unsigned p    = $urandom_range(0, 7);
      int unsigned mode = $urandom_range(0, 3);
      logic        im   = 1'($urandom_range(0, 1));
      logic [31:0] cval = {28'h0, im, 2'(mode), 1'b1};
      logic [31:0] cexp;
      int unsigned len  = 3 * (run_len(p) + 3);
      do_reset();
      wr(A_PRESET, p);
      wr(A_CTRL, cval);
      addr = A_COUNT;
      for (int unsigned k = 1; k <= len + 2; k++) begin
        @(negedge clk);
        if (k >= 2) begin
          checks++;
          if (rdata !== exp_count(p, mode, k - 2) || irq !== exp_irq(p, mode, im, k - 2)) begin
            errors++;
            $display("FAIL rand%0d_p%0d_mode%0d_im%0b_m%0d: count=%0d irq=%b expected count=%0d irq=%b",
                     t, p, mode, im, k - 2, rdata, irq,
                     exp_count(p, mode, k - 2), exp_irq(p, mode, im, k - 2));
          end
        end
      end
      cexp = (mode == 1) ? cval : (cval & ~32'h1);
      addr = A_CTRL; #1;
      checks++;
      if (rdata !== cexp) begin
        errors++;
        $display("FAIL rand%0d_ctrl: got %h expected %h", t, rdata, cexp);
      end
    end
  endtask

  initial begin
    reset = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    @(negedge clk);
    test_reset();
    test_oneshot();
    test_periodic();
    test_freeze();
    test_p0_p1();
    test_async_reset();
    test_int_collision();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/timer_counter.md
Name: timer_counter

Overview:
- Memory-mapped down-counting timer on the CPU's data bus, downstream of the core's M-stage data port (via the system bridge).
- Its interrupt output feeds one bit of the core's HWInt[5:0].
- Two instances (Timer0, Timer1) are planned; each decodes only word offsets 0x0/0x4/0x8.
- Provides the periodic and one-shot interrupt sources the exception/EPC path is tested against.

Parameters:
PRESET_INIT, 32'h0000_0000, reset value of PRESET
CTRL_MASK, 32'h0000_000F, writable CTRL bits; others read 0

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
addr  input  32  byte address from data bus; only addr[3:2] decoded
we  input  1  write strobe, already qualified by bridge address select and byte enables
wdata  input  32  write data (full word; partial writes not supported)
rdata  output  32  combinational read data for addr[3:2]
irq  output  1  interrupt request to CPU HWInt bit

Behaviour:
Registers:
- CTRL (offset 0x0): [0] EN, [2:1] MODE, [3] IM.
- PRESET (0x4): read/write.
- COUNT (0x8): read-only; writes ignored.
- Offset 0xC reads 0.

Reset (reset==0, async):
- CTRL=0, PRESET=PRESET_INIT, COUNT=0, state=IDLE, irq_flag=0.
- Output irq=0; rdata follows reset register values.

FSM states and transitions (evaluated every edge):
- IDLE: EN=1 -> LOAD; else stay.
- LOAD: COUNT<=PRESET; -> CNT.
- CNT: EN=0 -> IDLE, COUNT held. Else if COUNT>1, COUNT<=COUNT-1. Else COUNT<=0, irq_flag<=1, -> INT.
- INT, MODE=00 (one-shot): EN<=0, -> IDLE; irq_flag stays 1.
- INT, MODE=01 (periodic): irq_flag<=0, -> IDLE. EN still 1, so the counter reloads via LOAD.
- MODE=10/11: treated as 00.

Interrupt output:
- irq = irq_flag & IM, registered-source, glitch-free.
- Mode 1 gives a 2-cycle irq pulse: the INT cycle plus the IDLE cycle, because the flag clears at the INT->IDLE edge and the pulse is visible from the CNT->INT edge.

Timing:
- Write of EN=1 at edge t gives LOAD at t+1 and CNT at t+2 with COUNT=P.
- irq_flag rises P edges after CNT entry for P>=1.
- P=0 behaves as P=1.

Bus writes:
- Take effect at the edge they are sampled.
- A write to CTRL clears irq_flag (acknowledge).
- A CTRL write in the same edge as INT's EN<=0 wins: the written CTRL value is kept.
- A PRESET write during CNT does not alter COUNT; it applies at the next LOAD.
- Writing CTRL with EN=0 during CNT freezes COUNT next edge and goes to IDLE.

Reads:
- rdata is combinational, with no side effects.
- Reading COUNT shows the pre-edge value.

Mid-operation reset:
- Asserting reset in any state forces the reset values immediately (asynchronous).
- Deassertion is synchronised by the top level; the block does not synchronise it.

Width rules:
- COUNT is an unsigned 32-bit count and never wraps below 0.
- CTRL unused bits are stored as 0 per CTRL_MASK.

Decomposition:
- Shared macros include holds:
  - offset constants TC_CTRL=2'b00, TC_PRESET=2'b01, TC_COUNT=2'b10
  - state encodings TC_IDLE/TC_LOAD/TC_CNT/TC_INT (2-bit)
  - CTRL field positions (EN, MODE, IM)
- Single module; no sub-module is warranted. The bridge instantiates it twice at bases 0x7F00 and 0x7F10.

Test Plan:
- Reset then read all offsets -> rdata 0x0, PRESET_INIT, 0x0, 0x0; irq=0; state IDLE.
- PRESET=5, CTRL=0x9 (IM=1, MODE=0, EN=1) -> COUNT 5,4,3,2,1,0 on successive CNT edges. irq rises 5 edges after CNT entry and stays 1. CTRL reads 0x8 after INT. Writing CTRL=0 drops irq next edge.
- PRESET=3, CTRL=0xB (MODE=1) -> irq pulses 2 cycles wide every 6 cycles (LOAD + 3 CNT + INT + IDLE). COUNT sequence 3,2,1,0 repeats; EN remains 1.
- During CNT at COUNT=4, write CTRL=0x8 (EN=0) -> COUNT frozen at 3, state IDLE, no irq. Re-enable -> reloads PRESET, not 3.
- PRESET=0 and PRESET=1 with EN=1, IM=1 -> irq after exactly 1 CNT edge in both cases. Write to COUNT offset of 0xFFFF -> ignored.
- Async reset asserted mid-CNT with irq=1 -> irq, CTRL and COUNT go 0 without a clock edge. Simultaneous INT (mode 0) and CTRL write 0x9 -> CTRL reads 0x9 afterwards.
